// File: rtl/spi_pkg.sv
// Shared types and constants for the transmit-only SPI master.
// SPI_MOSI_INV_EN selects the line polarity applied by spi_line_bit.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        SHIFT_HI = 3'd2,
        SHIFT_LO = 3'd3,
        HOLD     = 3'd4
    } spi_tx_state_t;

    localparam logic SPI_SCK_IDLE  = 1'b0;
    localparam logic SPI_CS_ACTIVE = 1'b0;

    // Maps a data bit to the level driven on mosi.
    function automatic logic spi_line_bit(input logic data_bit);
`ifdef SPI_MOSI_INV_EN
        return ~data_bit;
`else
        return data_bit;
`endif
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// Down-counter timing every SPI phase; reloaded on each state entry,
// expire marks the last cycle of the phase. Never wraps below zero.
module spi_sck_gen #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt_r;

    // Phase counter: load wins, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - W'(1);
        end
    end

    assign expire = (cnt_r == W'(1));

endmodule

// File: rtl/spi_master_out.sv
// Transmit-only SPI master, mode 0, MSB first. Option macro: SPI_MOSI_INV_EN
// (mosi carries complemented data). Pins are one register stage behind the FSM.
module spi_master_out #(
    parameter int BITS     = 32,
    parameter int CLKDIV   = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [BITS-1:0] tx_data,
    input  logic            tx_valid,
    output logic            tx_ready,
    output logic            busy,
    output logic            done,
    output logic            cs,
    output logic            sck,
    output logic            mosi
);
    import spi_pkg::*;

    localparam int DW = $clog2(CLKDIV + CS_SETUP + CS_HOLD + 1);
    localparam int BW = $clog2(BITS + 1);

    spi_tx_state_t   state_r, state_s;
    logic [BITS-1:0] shift_r;
    logic [BW-1:0]   bit_cnt_r;
    logic            accept_s, last_bit_s, div_load_s, div_expire_s;
    logic [DW-1:0]   div_val_s;
    logic            cs_s, sck_s, mosi_s, done_s, busy_s;
    logic            cs_r, sck_r, mosi_r, done_r, busy_r;

    assign accept_s   = tx_valid && (state_r == IDLE);
    assign last_bit_s = (bit_cnt_r == BW'(BITS - 1));
    assign tx_ready   = (state_r == IDLE);

    spi_sck_gen #(.W(DW)) u_sck_gen (
        .clk      (clk),
        .reset    (reset),
        .load     (div_load_s),
        .load_val (div_val_s),
        .expire   (div_expire_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic and phase-length selection for the divider.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:     if (accept_s)     state_s = SETUP;    else state_s = IDLE;
            SETUP:    if (div_expire_s) state_s = SHIFT_HI; else state_s = SETUP;
            SHIFT_HI: if (div_expire_s) state_s = SHIFT_LO; else state_s = SHIFT_HI;
            SHIFT_LO: begin
                if (div_expire_s) begin
                    if (last_bit_s) state_s = HOLD; else state_s = SHIFT_HI;
                end else begin
                    state_s = SHIFT_LO;
                end
            end
            HOLD:     if (div_expire_s) state_s = IDLE;     else state_s = HOLD;
            default:  state_s = IDLE;
        endcase
        div_load_s = (state_s != state_r);
        case (state_s)
            SETUP:    div_val_s = DW'(CS_SETUP);
            SHIFT_HI: div_val_s = DW'(CLKDIV);
            SHIFT_LO: div_val_s = DW'(CLKDIV);
            HOLD:     div_val_s = DW'(CS_HOLD);
            default:  div_val_s = '0;
        endcase
    end

    // Shift register and bit counter; the bit advances as the next high phase begins.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_r   <= '0;
            bit_cnt_r <= '0;
        end else if (accept_s) begin
            shift_r   <= tx_data;
            bit_cnt_r <= '0;
        end else if ((state_r == SHIFT_LO) && div_expire_s && !last_bit_s) begin
            shift_r   <= {shift_r[BITS-2:0], 1'b0};
            bit_cnt_r <= bit_cnt_r + BW'(1);
        end else begin
            shift_r   <= shift_r;
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Pin values derived from the current state; done fires while the pins leave HOLD.
    always_comb begin
        cs_s   = (state_r == IDLE) ? ~SPI_CS_ACTIVE : SPI_CS_ACTIVE;
        sck_s  = (state_r == SHIFT_HI) ? ~SPI_SCK_IDLE : SPI_SCK_IDLE;
        mosi_s = (state_r == IDLE) ? 1'b0 : spi_line_bit(shift_r[BITS-1]);
        done_s = (state_r == IDLE) && (cs_r == SPI_CS_ACTIVE);
        busy_s = (state_s != IDLE);
    end

    // Output register stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_r   <= ~SPI_CS_ACTIVE;
            sck_r  <= SPI_SCK_IDLE;
            mosi_r <= 1'b0;
            done_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            cs_r   <= cs_s;
            sck_r  <= sck_s;
            mosi_r <= mosi_s;
            done_r <= done_s;
            busy_r <= busy_s;
        end
    end

    assign cs   = cs_r;
    assign sck  = sck_r;
    assign mosi = mosi_r;
    assign done = done_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_spi_master_out.sv
// Self-checking bench for spi_master_out: vector table, random words against a
// bit-sequence model, back-to-back, ignored request, reset abort, 32-bit loopback.
module tb_spi_master_out;

    localparam int BITS     = 8;
    localparam int CLKDIV   = 2;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_LOW   = CS_SETUP + 2 * CLKDIV * BITS + CS_HOLD;
    localparam int DONE_LAT = 1 + CS_LOW;
    localparam int B2_LAT   = 1 + 2 + 2 * 3 * 32 + 2;
`ifdef SPI_MOSI_INV_EN
    localparam logic [7:0]  INV8  = 8'hFF;
    localparam logic [31:0] INV32 = 32'hFFFF_FFFF;
`else
    localparam logic [7:0]  INV8  = 8'h00;
    localparam logic [31:0] INV32 = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready, busy, done, cs, sck, mosi;
    logic [31:0] t2_data;
    logic        t2_valid;
    logic        t2_ready, t2_busy, t2_done, t2_cs, t2_sck, t2_mosi;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_master_out #(.BITS(BITS), .CLKDIV(CLKDIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) u_dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done), .cs(cs), .sck(sck), .mosi(mosi)
    );

    spi_master_out #(.BITS(32), .CLKDIV(3), .CS_SETUP(2), .CS_HOLD(2)) u_dut32 (
        .clk(clk), .reset(reset), .tx_data(t2_data), .tx_valid(t2_valid), .tx_ready(t2_ready),
        .busy(t2_busy), .done(t2_done), .cs(t2_cs), .sck(t2_sck), .mosi(t2_mosi)
    );

    typedef struct {
        logic [7:0] data;
        logic [7:0] bits_true;  // sequence seen at the sck falls, first bit in MSB
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] line_word(input logic [7:0] d);
        return d ^ INV8;
    endfunction

    // Called at a negedge; returns at the negedge just after the accept edge.
    task automatic start_frame(input logic [7:0] d, input bit hold, input logic [7:0] next_d);
        int w = 0;
        while (!tx_ready && w < 200) begin
            @(posedge clk); @(negedge clk);
            w++;
        end
        check("ready_before_start", 32'(tx_ready), 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        if (hold) begin
            tx_data = next_d;
        end else begin
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
        end
    endtask

    // Follows one frame from the accept edge until done, sampling mosi at each sck fall.
    task automatic watch(input int glitch_k, output logic [7:0] rx, output int cs_low,
                         output int done_k, output logic ready_pre, output logic first_cs,
                         output int nfalls);
        logic prev_sck;
        prev_sck = sck; rx = 8'h00; cs_low = 0; done_k = 0;
        ready_pre = 1'b0; first_cs = 1'b1; nfalls = 0;
        for (int k = 1; k <= 400 && done_k == 0; k++) begin
            if (glitch_k > 0 && k == glitch_k) begin
                tx_data = 8'hFF; tx_valid = 1'b1;
            end else if (glitch_k > 0 && k == glitch_k + 1) begin
                tx_valid = 1'b0;
            end
            ready_pre = tx_ready;
            @(posedge clk); @(negedge clk);
            if (k == 1) first_cs = cs;
            if (!cs) cs_low++;
            if (prev_sck && !sck) begin
                rx = {rx[6:0], mosi};
                nfalls++;
            end
            prev_sck = sck;
            if (done) done_k = k;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[6];
        logic [7:0] rx, d;
        int         cs_low, done_k, nfalls, rises, stray;
        logic       ready_pre, first_cs, prev;
        logic [31:0] buf32;

        tbl[0] = '{8'hA5, 8'hA5};
        tbl[1] = '{8'h3C, 8'h3C};
        tbl[2] = '{8'h00, 8'h00};
        tbl[3] = '{8'hFF, 8'hFF};
        tbl[4] = '{8'h01, 8'h01};
        tbl[5] = '{8'h80, 8'h80};

        reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; t2_valid = 1'b0; t2_data = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cs",   32'(cs),   32'd1);
        check("reset_sck",  32'(sck),  32'd0);
        check("reset_mosi", 32'(mosi), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        check("ready_after_reset", 32'(tx_ready), 32'd1);

        // Test 1: single frame with detailed timing.
        start_frame(8'hA5, 1'b0, 8'h00);
        check("busy_after_accept",  32'(busy),     32'd1);
        check("ready_after_accept", 32'(tx_ready), 32'd0);
        check("cs_at_accept_cycle", 32'(cs),       32'd1);
        watch(-1, rx, cs_low, done_k, ready_pre, first_cs, nfalls);
        check("a5_bits",     32'(rx),     32'(line_word(8'hA5)));
        check("a5_falls",    32'(nfalls), 32'(BITS));
        check("a5_cs_low",   32'(cs_low), 32'(CS_LOW));
        check("a5_done_lat", 32'(done_k), 32'(DONE_LAT));
        check("a5_cs_end",   32'(cs),     32'd1);
        check("a5_mosi_end", 32'(mosi),   32'd0);
        @(posedge clk); @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);

        // Table of fixed words.
        for (int i = 0; i < 6; i++) begin
            start_frame(tbl[i].data, 1'b0, 8'h00);
            watch(-1, rx, cs_low, done_k, ready_pre, first_cs, nfalls);
            check("tbl_bits",     32'(rx),     32'(tbl[i].bits_true ^ INV8));
            check("tbl_done_lat", 32'(done_k), 32'(DONE_LAT));
        end

        // Random words against the MSB-first model.
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            start_frame(d, 1'b0, 8'h00);
            watch(-1, rx, cs_low, done_k, ready_pre, first_cs, nfalls);
            check("rnd_bits",   32'(rx),     32'(line_word(d)));
            check("rnd_cs_low", 32'(cs_low), 32'(CS_LOW));
        end

        // Back-to-back with tx_valid held high.
        start_frame(8'h3C, 1'b1, 8'hC3);
        watch(-1, rx, cs_low, done_k, ready_pre, first_cs, nfalls);
        check("b2b_first_bits",  32'(rx),        32'(line_word(8'h3C)));
        check("b2b_first_done",  32'(done_k),    32'(DONE_LAT));
        check("b2b_ready_at_acc", 32'(ready_pre), 32'd1);
        check("b2b_cs_gap",      32'(cs),        32'd1);
        tx_valid = 1'b0;
        watch(-1, rx, cs_low, done_k, ready_pre, first_cs, nfalls);
        check("b2b_cs_relow",    32'(first_cs),  32'd0);
        check("b2b_second_bits", 32'(rx),        32'(line_word(8'hC3)));
        check("b2b_second_done", 32'(done_k),    32'(DONE_LAT));

        // Request while busy is ignored.
        start_frame(8'h24, 1'b0, 8'h00);
        watch(10, rx, cs_low, done_k, ready_pre, first_cs, nfalls);
        check("busy_req_bits", 32'(rx),     32'(line_word(8'h24)));
        check("busy_req_done", 32'(done_k), 32'(DONE_LAT));
        stray = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); @(negedge clk);
            if (!cs || busy) stray++;
        end
        check("busy_req_no_frame", 32'(stray), 32'd0);

        // Reset during the 4th high phase of sck.
        start_frame(8'h5A, 1'b0, 8'h00);
        rises = 0; prev = sck;
        for (int k = 0; k < 100 && rises < 4; k++) begin
            @(posedge clk); @(negedge clk);
            if (!prev && sck) rises++;
            prev = sck;
        end
        check("rst_rise_seen", 32'(rises), 32'd4);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        check("rst_cs",   32'(cs),   32'd1);
        check("rst_sck",  32'(sck),  32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        stray = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); @(negedge clk);
            if (done || !cs) stray++;
        end
        check("rst_no_done", 32'(stray), 32'd0);
        start_frame(8'h81, 1'b0, 8'h00);
        watch(-1, rx, cs_low, done_k, ready_pre, first_cs, nfalls);
        check("rst_after_bits", 32'(rx),     32'(line_word(8'h81)));
        check("rst_after_done", 32'(done_k), 32'(DONE_LAT));

        // 32-bit loopback into a modelled input slave that undoes the line polarity.
        t2_data = 32'hDEAD_BEEF; t2_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        t2_valid = 1'b0; t2_data = 32'h0;
        buf32 = 32'h0; nfalls = 0; done_k = 0; prev = t2_sck;
        for (int k = 1; k <= 600 && done_k == 0; k++) begin
            @(posedge clk); @(negedge clk);
            if (prev && !t2_sck) begin
                buf32 = {buf32[30:0], t2_mosi};
                nfalls++;
            end
            prev = t2_sck;
            if (t2_done) done_k = k;
        end
        check("lb32_out_buf", buf32 ^ INV32, 32'hDEAD_BEEF);
        check("lb32_falls",   32'(nfalls),   32'd32);
        check("lb32_done",    32'(done_k),   32'(B2_LAT));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
